// File: rtl/rv32i_muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Operands are captured as magnitudes with sign flags on issue. The unit then runs
// N iterations: shift-add for multiplies, restoring shift-subtract for divides.
// Sign correction and result selection are registered on entry to the one-cycle DONE state.
module rv32i_muldiv_unit #(
   parameter int DATA_BUS_WIDTH = 32,
   parameter int NUM_OF_SETS    = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [2:0]                     funct3,
   input  logic [DATA_BUS_WIDTH-1:0]      op_a,
   input  logic [DATA_BUS_WIDTH-1:0]      op_b,
   input  logic [$clog2(NUM_OF_SETS)-1:0] rd_in,
   output logic                           busy,
   output logic                           done,
   output logic                           wr_enable,
   output logic [$clog2(NUM_OF_SETS)-1:0] wr_addr,
   output logic [DATA_BUS_WIDTH-1:0]      wr_data
);

   localparam int N  = DATA_BUS_WIDTH;
   localparam int AW = $clog2(NUM_OF_SETS);
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state, state_next;

   // Iteration state: {carry/remainder, product/quotient}
   logic [2*N:0]         acc;
   logic [N-1:0]         opnd;
   logic [N-1:0]         a_raw;
   logic [2:0]           f3_q;
   logic [AW-1:0]        rd_q;
   logic                 neg_res;
   logic                 neg_rem;
   logic                 b_zero;
   logic [CW-1:0]        count;

   logic signed [N-1:0]  op_a_s;
   logic signed [N-1:0]  op_b_s;
   logic                 a_signed;
   logic                 b_signed;
   logic                 a_neg;
   logic                 b_neg;
   logic [N-1:0]         a_mag;
   logic [N-1:0]         b_mag;

   logic [N:0]           mul_sum;
   logic [2*N:0]         mul_next;
   logic [2*N:0]         div_sh;
   logic [N:0]           div_diff;
   logic [2*N:0]         div_next;

   logic [2*N-1:0]       product;
   logic [N-1:0]         quot;
   logic [N-1:0]         rem;
   logic [N-1:0]         result;

   // Conditional two's-complement negate, result width
   function automatic logic [N-1:0] neg_n(input logic [N-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

   // Conditional two's-complement negate, full product width
   function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v, input logic en);
      return en ? (~v + 1'b1) : v;
   endfunction

   assign op_a_s = op_a;
   assign op_b_s = op_b;

   // Issue-time operand conditioning: signedness per opcode, magnitudes
   always_comb begin
      a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      a_neg    = a_signed && (op_a_s < $signed(N'(0)));
      b_neg    = b_signed && (op_b_s < $signed(N'(0)));
      a_mag    = neg_n(op_a, a_neg);
      b_mag    = neg_n(op_b, b_neg);
   end

   // One multiply step (shift-add) and one divide step (restoring shift-subtract)
   always_comb begin
      mul_sum  = acc[2*N:N] + {1'b0, (acc[0] ? opnd : {N{1'b0}})};
      mul_next = {1'b0, mul_sum, acc[N-1:1]};
      div_sh   = {acc[2*N-1:0], 1'b0};
      div_diff = div_sh[2*N:N] - {1'b0, opnd};
      div_next = div_diff[N] ? div_sh : {div_diff, div_sh[N-1:1], 1'b1};
   end

   // Sign correction, divide-by-zero override and result selection
   always_comb begin
      product = neg_2n(acc[2*N-1:0], neg_res);
      quot    = b_zero ? {N{1'b1}} : neg_n(acc[N-1:0], neg_res);
      rem     = b_zero ? a_raw : neg_n(acc[2*N-1:N], neg_rem);
      case (f3_q)
         3'b000:                 result = product[N-1:0];
         3'b001, 3'b010, 3'b011: result = product[2*N-1:N];
         3'b100, 3'b101:         result = quot;
         default:                result = rem;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // FSM next state and status outputs
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      wr_enable  = 1'b0;
      case (state)
         IDLE: if (start) state_next = CALC;
         CALC: begin
            busy = 1'b1;
            if (count == LAST) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            wr_enable  = (rd_q != '0);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, iteration and write-back registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         opnd    <= '0;
         a_raw   <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         b_zero  <= 1'b0;
         count   <= '0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               f3_q    <= funct3;
               rd_q    <= rd_in;
               a_raw   <= op_a;
               b_zero  <= (op_b == '0);
               neg_res <= a_neg ^ b_neg;
               neg_rem <= a_neg;
               count   <= '0;
               // Divide iterates over the dividend, multiply over the multiplier
               if (funct3[2]) begin
                  acc  <= {{(N+1){1'b0}}, a_mag};
                  opnd <= b_mag;
               end else begin
                  acc  <= {{(N+1){1'b0}}, b_mag};
                  opnd <= a_mag;
               end
            end
            CALC: begin
               if (count != LAST) begin
                  acc   <= f3_q[2] ? div_next : mul_next;
                  count <= count + 1'b1;
               end else begin
                  wr_data <= result;
                  wr_addr <= rd_q;
                  count   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_muldiv_unit.sv
// Self-checking bench for rv32i_muldiv_unit: directed cases plus randomized operations
// against an arithmetic reference model.
module tb_rv32i_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic        wr_enable;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int checks = 0;
   int errors = 0;

   rv32i_muldiv_unit #(.DATA_BUS_WIDTH(32), .NUM_OF_SETS(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
      .rd_in(rd_in), .busy(busy), .done(done), .wr_enable(wr_enable),
      .wr_addr(wr_addr), .wr_data(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no end of run, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Reference results from plain integer arithmetic
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      int          sa;
      int          sb;
      longint      p;
      logic [63:0] up;
      sa = a;
      sb = b;
      case (f3)
         3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
         3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
         3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation, follow it to IDLE and check timing and write-back
   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input bit hold,
                         input logic [31:0] exp);
      int          done_cnt;
      int          done_at;
      int          idle_at;
      logic        we_s;
      logic [4:0]  wa_s;
      logic [31:0] wd_s;
      done_cnt = 0;
      done_at  = -1;
      idle_at  = -1;
      we_s     = 1'b0;
      wa_s     = '0;
      wd_s     = '0;
      funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      chk({name, "_busy"}, busy, 1);
      for (int k = 1; k <= 40 && idle_at < 0; k++) begin
         if (hold) begin
            op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
         end
         @(posedge clk); #1;
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = k; we_s = wr_enable; wa_s = wr_addr; wd_s = wr_data;
            end
         end
         if (!busy) idle_at = k;
      end
      start = 1'b0;
      chk({name, "_done_lat"}, done_at, 33);
      chk({name, "_idle_lat"}, idle_at, 34);
      chk({name, "_done_cnt"}, done_cnt, 1);
      chk({name, "_wr_en"}, we_s, (rd != 5'd0));
      chk({name, "_wr_addr"}, wa_s, rd);
      chk({name, "_wr_data"}, wd_s, exp);
      @(posedge clk); #1;
      chk({name, "_hold"}, wr_data, exp);
      chk({name, "_idle"}, {busy, done, wr_enable}, 3'b000);
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          sel;
      rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
      #2 rst = 1'b0;
      #1;
      chk("reset_outputs", {busy, done, wr_enable, wr_addr, wr_data}, '0);
      @(posedge clk); @(posedge clk); #1 rst = 1'b1;

      run_op("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  1'b0, 32'hFFFF_FFEB);
      run_op("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  1'b0, 32'h4000_0000);
      run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  1'b0, 32'hFFFF_FFFE);
      run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  1'b0, 32'hFFFF_FFFF);
      run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2,         5'd4,  1'b0, 32'hFFFF_FFFD);
      run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6,  1'b0, 32'hFFFF_FFFF);
      run_op("divu_z",  3'b101, 32'd5,         32'd0,         5'd7,  1'b0, 32'hFFFF_FFFF);
      run_op("remu_z",  3'b111, 32'd5,         32'd0,         5'd8,  1'b0, 32'd5);
      run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  1'b0, 32'h8000_0000);
      run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0, 32'd0);
      run_op("rd0_hold", 3'b000, 32'd6,        32'd7,         5'd0,  1'b1, 32'd42);

      // Abort a DIVU mid-calculation with an asynchronous reset
      funct3 = 3'b101; op_a = $urandom; op_b = $urandom | 32'd1; rd_in = 5'd9; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_outputs", {busy, done, wr_enable, wr_addr, wr_data}, '0);
      @(posedge clk); @(posedge clk); #1;
      chk("abort_quiet", {busy, done, wr_enable, wr_data}, '0);
      rst = 1'b1;
      run_op("post_rst", 3'b000, 32'd3, 32'd4, 5'd7, 1'b0, 32'd12);

      for (int i = 0; i < 24; i++) begin
         f   = 3'($urandom);
         a   = $urandom;
         b   = $urandom;
         rd  = 5'($urandom);
         sel = $urandom_range(0, 5);
         if (sel == 0) b = 32'd0;
         if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if (sel == 2) b = 32'($urandom_range(1, 15));
         run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, rd, (i % 4) == 3, ref_result(f, a, b));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
